// File: rtl/matrix_pkg.sv
// Shared types and helpers for the result write-back path.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } wr_state_t;

    localparam logic [15:0] OUT_HEAD_ADDR   = 16'h0200;
    localparam logic [15:0] ZERO_POINT_ADDR = 16'h0100;

    // Clamp a signed value into the int8 range.
    function automatic logic [7:0] sat8(input logic signed [63:0] v);
        if (v > 64'sd127) begin
            return 8'h7F;
        end else if (v < -64'sd128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/res_fifo.sv
// Synchronous result FIFO with first-word-fall-through head and full/empty flags.
module res_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; not reset, emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_writer.sv
// Captures accumulator results during the read phase, requantizes them to int8
// and writes them to consecutive output addresses over a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for the first read cycle; that cycle also captures
// ACTIVE | capturing and draining concurrently until write exp_cnt completes
// DONE   | one-cycle done pulse, counters cleared, back to IDLE
module result_writer #(
    parameter int               ADDR_SIZE     = 10,
    parameter int               ACC_W         = 32,
    parameter int               DEPTH         = 64,
    parameter logic [15:0]      OUT_HEAD_ADDR = matrix_pkg::OUT_HEAD_ADDR,
    parameter int               SHIFT         = 8,
    parameter logic signed [7:0] OUT_ZP       = 8'sd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic [7:0]           column_size,
    input  logic [ACC_W-1:0]     res_data,
    output logic                 wr_valid,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [7:0]           wr_data,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    import matrix_pkg::*;

    wr_state_t state_q;
    wr_state_t state_d;

    logic [7:0]              exp_cnt;
    logic [7:0]              cap_cnt;
    logic [7:0]              wr_cnt;
    logic [7:0]              exp_eff;
    logic [7:0]              cap_eff;
    logic [7:0]              wr_cnt_next;
    logic                    accepting;
    logic                    hs;
    logic                    last_write;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ACC_W-1:0]        fifo_head;
    logic signed [ACC_W-1:0] head_shifted;
    logic signed [ACC_W:0]   head_sum;
    logic [7:0]              head_q8;

    res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ACC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (res_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Capture gating and drain handshake; in IDLE the live column_size stands
    // in for exp_cnt so the very first read cycle is not lost.
    always_comb begin
        exp_eff     = (state_q == IDLE) ? column_size : exp_cnt;
        cap_eff     = (state_q == IDLE) ? 8'd0 : cap_cnt;
        accepting   = (state_q == IDLE) || (state_q == ACTIVE);
        fifo_push   = read && accepting && (cap_eff < exp_eff) && !fifo_full;
        hs          = wr_valid && wr_ready;
        fifo_pop    = !fifo_empty && (!wr_valid || wr_ready);
        wr_cnt_next = wr_cnt + {7'd0, hs};
        last_write  = hs && (({1'b0, wr_cnt} + 9'd1) == {1'b0, exp_cnt});
    end

    // Requantization of the FIFO head: arithmetic shift, zero point, int8 clamp.
    always_comb begin
        head_shifted = $signed(fifo_head) >>> SHIFT;
        head_sum     = {head_shifted[ACC_W-1], head_shifted}
                     + {{(ACC_W-7){OUT_ZP[7]}}, OUT_ZP};
        head_q8      = sat8({{(63-ACC_W){head_sum[ACC_W]}}, head_sum});
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (read) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if ((exp_cnt == 8'd0) || last_write) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run counters and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_cnt  <= 8'd0;
            cap_cnt  <= 8'd0;
            wr_cnt   <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if ((state_q == IDLE) && read) begin
                exp_cnt <= column_size;
            end
            if (state_q == DONE) begin
                cap_cnt <= 8'd0;
                wr_cnt  <= 8'd0;
            end else begin
                if (fifo_push) begin
                    cap_cnt <= cap_eff + 8'd1;
                end
                wr_cnt <= wr_cnt_next;
            end
            if (read && !fifo_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Registered write port; a new entry loads whenever the port is free or
    // being accepted this cycle, otherwise address and data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
        end else if (fifo_pop) begin
            wr_valid <= 1'b1;
            wr_addr  <= ADDR_SIZE'(OUT_HEAD_ADDR) + ADDR_SIZE'(wr_cnt_next);
            wr_data  <= head_q8;
        end else if (hs) begin
            wr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: two instances (zero point 0 and 5) share
// stimulus; expected writes are queued at stimulus time and popped on handshake.
module tb_result_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        wr_ready;
    logic [7:0]  column_size;
    logic [31:0] res_data;

    logic        wr_valid, wr_valid_z;
    logic [9:0]  wr_addr, wr_addr_z;
    logic [7:0]  wr_data, wr_data_z;
    logic        busy, busy_z;
    logic        done, done_z;
    logic        overflow, overflow_z;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_cnt_z = 0;
    int hs_cnt = 0;

    // entry = {addr[9:0], data_zp0[7:0], data_zp5[7:0]}
    logic [25:0] q[$];
    logic [31:0] vec [128];

    logic       stall_p, stall_pz;
    logic [9:0] st_addr, st_addr_z;
    logic [7:0] st_data, st_data_z;

    always #5 clk = ~clk;

    result_writer dut (
        .clk(clk), .reset(reset), .read(read), .column_size(column_size),
        .res_data(res_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done),
        .overflow(overflow)
    );

    result_writer #(.OUT_ZP(8'sd5)) dut_zp (
        .clk(clk), .reset(reset), .read(read), .column_size(column_size),
        .res_data(res_data), .wr_valid(wr_valid_z), .wr_addr(wr_addr_z),
        .wr_data(wr_data_z), .wr_ready(wr_ready), .busy(busy_z), .done(done_z),
        .overflow(overflow_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rq(input logic [31:0] x, input int zp);
        int v;
        v = ($signed(x) >>> 8) + zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    // Monitor: stall stability, handshake scoreboard, done pulse counting.
    always @(negedge clk) begin
        if (reset) begin
            stall_p  = 1'b0;
            stall_pz = 1'b0;
        end else begin
            if (stall_p) begin
                check("stall_valid", wr_valid, 1);
                check("stall_addr", wr_addr, st_addr);
                check("stall_data", wr_data, st_data);
            end
            if (stall_pz) begin
                check("stall_data_zp", wr_data_z, st_data_z);
                check("stall_addr_zp", wr_addr_z, st_addr_z);
            end
            if (wr_valid && wr_ready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected", wr_addr, wr_data);
                end else begin
                    logic [25:0] e;
                    e = q.pop_front();
                    check("wr_addr", wr_addr, e[25:16]);
                    check("wr_data", wr_data, e[15:8]);
                    check("zp_valid", wr_valid_z, 1);
                    check("zp_addr", wr_addr_z, e[25:16]);
                    check("zp_data", wr_data_z, e[7:0]);
                end
            end
            if (done)   done_cnt++;
            if (done_z) done_cnt_z++;
            stall_p   = wr_valid && !wr_ready;
            st_addr   = wr_addr;
            st_data   = wr_data;
            stall_pz  = wr_valid_z && !wr_ready;
            st_addr_z = wr_addr_z;
            st_data_z = wr_data_z;
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        read     = 1'b0;
        wr_ready = 1'b0;
        res_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    // rmode: 0 ready always, 1 ready toggles (low on even cycles), 2 ready low until cycle hold
    task automatic run(input int ncol, input int nread, input int rmode, input int hold,
                       input logic expect_ovf);
        int d0, dz0, n;
        logic fin;
        d0  = done_cnt;
        dz0 = done_cnt_z;
        n   = (ncol < nread) ? ncol : nread;
        fin = 1'b0;
        for (int i = 0; i < n; i++) begin
            q.push_back({10'(32'h200 + i), rq(vec[i], 0), rq(vec[i], 5)});
        end
        column_size = 8'(ncol);
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clk);
            #1;
            read     = (c < nread);
            res_data = (c < nread) ? vec[c] : 32'h0;
            case (rmode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = c[0];
                default: wr_ready = (c >= hold);
            endcase
            if (done_cnt != d0 && c >= nread) fin = 1'b1;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL run_timeout: no done pulse within 400 cycles (col=%0d)", ncol);
        end
        read     = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("done_pulses_zp", done_cnt_z - dz0, 1);
        check("overflow", overflow, expect_ovf);
        check("pending_writes", q.size(), 0);
        check("busy_after", busy, 0);
        check("valid_after", wr_valid, 0);
    endtask

    initial begin
        int h0;
        logic fin;

        reset = 1'b1; read = 1'b0; wr_ready = 1'b0; column_size = 8'd0; res_data = 32'h0;
        stall_p = 1'b0; stall_pz = 1'b0;
        do_reset();
        check("rst_valid", wr_valid, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);

        // basic run with ready always high
        vec[0] = 32'd256; vec[1] = 32'd512; vec[2] = 32'hFFFF_FF00; vec[3] = 32'h7FFF_FFFF;
        run(4, 4, 0, 0, 1'b0);

        // same data with ready toggling
        do_reset();
        run(4, 4, 1, 0, 1'b0);

        // negative saturation and zero point
        do_reset();
        vec[0] = 32'hF000_0000; vec[1] = 32'h0;
        run(2, 2, 0, 0, 1'b0);

        // extra read beyond column_size
        vec[0] = 32'd2560; vec[1] = 32'hFFFF_EC00; vec[2] = 32'd7680;
        run(2, 3, 0, 0, 1'b1);

        // overflow stays set across a clean run
        vec[0] = 32'd1024;
        run(1, 1, 0, 0, 1'b1);

        // column_size of zero
        do_reset();
        run(0, 1, 0, 0, 1'b1);

        // reset in the middle of a run
        do_reset();
        vec[0] = 32'd256; vec[1] = 32'd512; vec[2] = 32'd768; vec[3] = 32'd1024;
        for (int i = 0; i < 4; i++) q.push_back({10'(32'h200 + i), rq(vec[i], 0), rq(vec[i], 5)});
        column_size = 8'd4;
        h0  = hs_cnt;
        fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(posedge clk);
            #1;
            read     = (c < 4);
            res_data = (c < 4) ? vec[c] : 32'h0;
            wr_ready = 1'b1;
            if (hs_cnt >= h0 + 2) fin = 1'b1;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL midrun_timeout: second write not seen within 50 cycles");
        end
        reset = 1'b1;
        read  = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", wr_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        reset = 1'b0;
        q.delete();
        run(4, 4, 0, 0, 1'b0);

        // full-depth run with writes stalled for 70 cycles
        do_reset();
        for (int i = 0; i < 64; i++) vec[i] = 32'(i * 512 - 16000);
        run(64, 64, 2, 70, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
